// File: rtl/window_read_scheduler.sv
// window_read_scheduler
// Read-side controller for the four-row line buffer that presents a
// three-row window. For every Start_Row pulse it walks the window read
// address over all column/channel-group beats of the row, absorbs the
// two-cycle read latency in a credit-limited skid FIFO, and streams the
// window words to the convolution engine under valid/ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   Start                 layer start; latches configuration, clears errors
//   Row_Num_After_Padding padded row length (also padded row count)
//   Channel_In_Num_REG    input channels; channel groups = value >> 4
//   Start_Row             window ready in the line buffer
//   Busy                  row in flight (line buffer M_Ready)
//   Rd_Addr               window read address (line buffer M_Addr)
//   Win_Data              window word, valid two cycles after Rd_Addr
//   M_Data/M_Valid/M_Ready window word stream to the engine
//   Col_Last              last beat of a row, qualified by M_Valid
//   Row_Done, Layer_Done  one-cycle completion pulses
//   Overrun_Err           sticky: Start_Row arrived while a row was in flight
module window_read_scheduler #(
    parameter int WIDTH_RAM_SIZE     = 10,
    parameter int WIDTH_FEATURE_SIZE = 12,
    parameter int WIDTH_CHANNEL_NUM  = 10,
    parameter int WIDTH_WINDOW       = 384,
    parameter int SKID_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Start,
    input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
    input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
    input  logic                          Start_Row,
    output logic                          Busy,
    output logic [WIDTH_RAM_SIZE-1:0]     Rd_Addr,
    input  logic [WIDTH_WINDOW-1:0]       Win_Data,
    output logic [WIDTH_WINDOW-1:0]       M_Data,
    output logic                          M_Valid,
    input  logic                          M_Ready,
    output logic                          Col_Last,
    output logic                          Row_Done,
    output logic                          Layer_Done,
    output logic                          Overrun_Err
);

    localparam int BEAT_W = WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM;
    localparam int PTR_W  = $clog2(SKID_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROW,
        S_SETTLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [BEAT_W-1:0]             beats_q, beats_d;
    logic [WIDTH_FEATURE_SIZE-1:0] rows_q, rows_d;
    logic [WIDTH_FEATURE_SIZE-1:0] rowCnt_q, rowCnt_d;
    logic [WIDTH_RAM_SIZE-1:0]     lastAddr_q, lastAddr_d;
    logic [1:0]                    pipeValid_q, pipeValid_d;
    logic [1:0]                    pipeLast_q, pipeLast_d;
    logic [PTR_W-1:0]              wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]              rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          overrun_q, overrun_d;
    logic                          rowDone_q, rowDone_d;
    logic                          layerDone_q, layerDone_d;
    logic [WIDTH_WINDOW:0]         fifoMem_q [SKID_DEPTH];

    logic [WIDTH_CHANNEL_NUM-1:0]  ctRaw;
    logic [WIDTH_CHANNEL_NUM-1:0]  ctEff;
    logic [CNT_W:0]                occupancy;
    logic                          credit;
    logic                          issue;
    logic                          lastBeat;
    logic                          push;
    logic                          pop;
    logic [WIDTH_WINDOW:0]         headWord;
    logic [WIDTH_FEATURE_SIZE-1:0] rowCntInc;

    // Layer configuration derived from the raw register inputs; a channel
    // count below 16 still needs one group per column.
    assign ctRaw = Channel_In_Num_REG >> 4;
    assign ctEff = (ctRaw == '0) ? WIDTH_CHANNEL_NUM'(1) : ctRaw;

    // Credits count reads still in the latency pipe plus words already
    // waiting in the FIFO, so every issued read is guaranteed a slot.
    assign occupancy = {1'b0, count_q}
                     + {{CNT_W{1'b0}}, pipeValid_q[0]}
                     + {{CNT_W{1'b0}}, pipeValid_q[1]};
    assign credit    = occupancy < (CNT_W + 1)'(SKID_DEPTH);
    assign issue     = (state_q == S_ISSUE) && credit;
    assign lastBeat  = (beat_q == beats_q - BEAT_W'(1));
    assign rowCntInc = rowCnt_q + WIDTH_FEATURE_SIZE'(1);

    // The beat index is the address (column*CT + group); between issues the
    // previously issued address is held.
    assign Rd_Addr = issue ? WIDTH_RAM_SIZE'(beat_q) : lastAddr_q;

    assign push     = pipeValid_q[1];
    assign pop      = M_Valid && M_Ready;
    assign headWord = fifoMem_q[rdPtr_q];

    assign M_Valid     = (count_q != '0);
    assign M_Data      = M_Valid ? headWord[WIDTH_WINDOW-1:0] : '0;
    assign Col_Last    = M_Valid && headWord[WIDTH_WINDOW];
    assign Busy        = (state_q == S_SETTLE) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign Row_Done    = rowDone_q;
    assign Layer_Done  = layerDone_q;
    assign Overrun_Err = overrun_q;

    // Next-state logic: row sequencing, address walk, latency pipe and FIFO
    // bookkeeping. A row only completes once the pipe and FIFO are empty,
    // which means the engine has accepted the final beat.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        beats_d     = beats_q;
        rows_d      = rows_q;
        rowCnt_d    = rowCnt_q;
        overrun_d   = overrun_q;
        rowDone_d   = 1'b0;
        layerDone_d = 1'b0;
        lastAddr_d  = issue ? WIDTH_RAM_SIZE'(beat_q) : lastAddr_q;
        pipeValid_d = {pipeValid_q[0], issue};
        pipeLast_d  = {pipeLast_q[0], issue && lastBeat};
        wrPtr_d     = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d     = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    beats_d   = BEAT_W'(Row_Num_After_Padding) * BEAT_W'(ctEff);
                    rows_d    = (Row_Num_After_Padding < WIDTH_FEATURE_SIZE'(3)) ? '0
                              : Row_Num_After_Padding - WIDTH_FEATURE_SIZE'(2);
                    rowCnt_d  = '0;
                    overrun_d = 1'b0;
                    state_d   = S_WAIT_ROW;
                end
            end
            S_WAIT_ROW: begin
                // A layer too short to form a window finishes immediately.
                if (rows_q == '0) begin
                    layerDone_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (Start_Row) begin
                    beat_d  = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (lastBeat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((pipeValid_q == 2'b00) && (count_q == '0)) begin
                    rowDone_d = 1'b1;
                    rowCnt_d  = rowCntInc;
                    if (rowCntInc == rows_q) begin
                        layerDone_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_WAIT_ROW;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (Start_Row && Busy) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            beats_q     <= '0;
            rows_q      <= '0;
            rowCnt_q    <= '0;
            lastAddr_q  <= '0;
            pipeValid_q <= '0;
            pipeLast_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            rowDone_q   <= 1'b0;
            layerDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            beats_q     <= beats_d;
            rows_q      <= rows_d;
            rowCnt_q    <= rowCnt_d;
            lastAddr_q  <= lastAddr_d;
            pipeValid_q <= pipeValid_d;
            pipeLast_q  <= pipeLast_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            rowDone_q   <= rowDone_d;
            layerDone_q <= layerDone_d;
        end
    end

    // Skid FIFO storage; contents are only observed through the occupancy
    // count, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {pipeLast_q[1], Win_Data};
        end
    end

endmodule

// File: tb/tb_window_read_scheduler.sv
// Testbench for window_read_scheduler: a line-buffer model returns a known
// word for every address two cycles later, and a scoreboard checks that each
// row streams every beat once, in address order, with the right Col_Last.
module tb_window_read_scheduler;

    localparam int W     = 384;
    localparam int RW    = 10;
    localparam int FW    = 12;
    localparam int CW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Start;
    logic [FW-1:0] Row_Num_After_Padding;
    logic [CW-1:0] Channel_In_Num_REG;
    logic          Start_Row;
    logic          Busy;
    logic [RW-1:0] Rd_Addr;
    logic [W-1:0]  Win_Data;
    logic [W-1:0]  M_Data;
    logic          M_Valid;
    logic          M_Ready;
    logic          Col_Last;
    logic          Row_Done;
    logic          Layer_Done;
    logic          Overrun_Err;

    int compareCount = 0;
    int failCount    = 0;

    bit          monOn       = 1'b0;
    bit          randReady   = 1'b0;
    int          stallCycles = 0;
    int          curBeats    = 1;
    logic [31:0] salt        = 32'h0;
    int          expBeat, acceptedRow, issuedRow, nextIssue, rowsDone, layerDones;
    int          h1 = 0;
    int          h2 = 0;

    window_read_scheduler #(
        .WIDTH_RAM_SIZE(RW), .WIDTH_FEATURE_SIZE(FW), .WIDTH_CHANNEL_NUM(CW),
        .WIDTH_WINDOW(W), .SKID_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start),
        .Row_Num_After_Padding(Row_Num_After_Padding),
        .Channel_In_Num_REG(Channel_In_Num_REG),
        .Start_Row(Start_Row), .Busy(Busy), .Rd_Addr(Rd_Addr),
        .Win_Data(Win_Data), .M_Data(M_Data), .M_Valid(M_Valid),
        .M_Ready(M_Ready), .Col_Last(Col_Last), .Row_Done(Row_Done),
        .Layer_Done(Layer_Done), .Overrun_Err(Overrun_Err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] wordOf(input int addr, input logic [31:0] s);
        logic [W-1:0] w;
        for (int k = 0; k < 12; k++) begin
            w[k*32 +: 32] = s ^ (32'(addr) * 32'h9E3779B1 + 32'(k));
        end
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic resetScoreboard();
        expBeat     = 0;
        acceptedRow = 0;
        issuedRow   = 0;
        nextIssue   = 0;
        rowsDone    = 0;
        layerDones  = 0;
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
    endtask

    task automatic pulseStartRow();
        @(posedge clk); #1 Start_Row = 1'b1;
        @(posedge clk); #1 Start_Row = 1'b0;
    endtask

    task automatic waitRows(input int target);
        int n = 0;
        while (rowsDone < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("row_wait", W'(rowsDone >= target), W'(1));
    endtask

    // Line buffer model: the word for an address appears two cycles later.
    initial begin
        Win_Data = '0;
        forever begin
            @(negedge clk);
            Win_Data = wordOf(h2, salt);
            h2 = h1;
            h1 = int'(Rd_Addr);
        end
    end

    // Engine ready: always-ready, random, or forced low for a stall window.
    initial begin
        M_Ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stallCycles > 0) begin
                M_Ready = 1'b0;
                stallCycles--;
            end else begin
                M_Ready = randReady ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    // Scoreboard: every valid head word must be the next beat of the row.
    initial begin
        resetScoreboard();
        forever begin
            @(negedge clk);
            if (monOn) begin
                if (Busy && nextIssue < curBeats && int'(Rd_Addr) == nextIssue) begin
                    nextIssue++;
                    issuedRow++;
                    checkOutput("outstanding_le_depth", W'(issuedRow - acceptedRow <= DEPTH), W'(1));
                end
                if (acceptedRow > 0 && acceptedRow < curBeats) begin
                    checkOutput("busy_mid_row", W'(Busy), W'(1));
                end
                if (M_Valid) begin
                    checkOutput("m_data", M_Data, wordOf(expBeat, salt));
                    checkOutput("col_last", W'(Col_Last), W'(expBeat == curBeats - 1));
                    if (M_Ready) begin
                        acceptedRow++;
                        expBeat++;
                    end
                end
                if (Row_Done) begin
                    checkOutput("row_beats_accepted", W'(acceptedRow), W'(curBeats));
                    checkOutput("busy_low_at_row_done", W'(Busy), W'(0));
                    rowsDone++;
                    expBeat     = 0;
                    acceptedRow = 0;
                    issuedRow   = 0;
                    nextIssue   = 0;
                end
                if (Layer_Done) begin
                    layerDones++;
                end
            end
        end
    end

    // One full layer: Start, then one Start_Row per window row, each
    // waiting for the previous Row_Done.
    task automatic applyStimulus(input int rowLen, input int chNum, input bit rnd,
                                 input bit timing, input int stallRow, input int overrunRow);
        int ct;
        int rows;
        ct       = ((chNum >> 4) == 0) ? 1 : (chNum >> 4);
        curBeats = rowLen * ct;
        rows     = rowLen - 2;
        randReady = rnd;
        salt      = $urandom;
        resetScoreboard();
        Row_Num_After_Padding = FW'(rowLen);
        Channel_In_Num_REG    = CW'(chNum);
        pulseStart();
        @(negedge clk);
        checkOutput("overrun_clear_on_start", W'(Overrun_Err), W'(0));
        for (int r = 0; r < rows; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            pulseStartRow();
            if (timing && r == 0) begin
                @(negedge clk);
                checkOutput("busy_after_start_row", W'(Busy), W'(1));
                for (int i = 0; i < curBeats; i++) begin
                    @(negedge clk);
                    checkOutput("rd_addr_seq", W'(Rd_Addr), W'(i));
                    if (i == 2) checkOutput("m_valid_not_yet", W'(M_Valid), W'(0));
                    if (i == 3) checkOutput("m_valid_first", W'(M_Valid), W'(1));
                end
            end
            if (r == stallRow) begin
                repeat (6) @(posedge clk);
                stallCycles = 10;
            end
            if (r == overrunRow) begin
                repeat (3) @(posedge clk);
                #1 Start_Row = 1'b1;
                @(posedge clk);
                #1 Start_Row = 1'b0;
                @(negedge clk);
                checkOutput("overrun_set", W'(Overrun_Err), W'(1));
            end
            waitRows(r + 1);
        end
        @(negedge clk);
        checkOutput("rows_done", W'(rowsDone), W'(rows));
        checkOutput("layer_done_count", W'(layerDones), W'(1));
        checkOutput("busy_idle_after_layer", W'(Busy), W'(0));
    endtask

    task automatic checkAllZero(input string prefix);
        checkOutput({prefix, "_busy"}, W'(Busy), W'(0));
        checkOutput({prefix, "_rd_addr"}, W'(Rd_Addr), W'(0));
        checkOutput({prefix, "_m_valid"}, W'(M_Valid), W'(0));
        checkOutput({prefix, "_m_data"}, M_Data, W'(0));
        checkOutput({prefix, "_col_last"}, W'(Col_Last), W'(0));
        checkOutput({prefix, "_row_done"}, W'(Row_Done), W'(0));
        checkOutput({prefix, "_layer_done"}, W'(Layer_Done), W'(0));
        checkOutput({prefix, "_overrun"}, W'(Overrun_Err), W'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        Start = 1'b0;
        Start_Row = 1'b0;
        Row_Num_After_Padding = '0;
        Channel_In_Num_REG = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        monOn = 1'b1;

        applyStimulus(6, 32, 1'b0, 1'b1, -1, -1);
        applyStimulus(6, 32, 1'b0, 1'b0, 1, -1);
        applyStimulus(10, 16, 1'b1, 1'b0, -1, -1);
        applyStimulus(6, 32, 1'b1, 1'b0, -1, 2);
        checkOutput("overrun_sticky", W'(Overrun_Err), W'(1));
        applyStimulus(5, 8, 1'b1, 1'b0, -1, -1);

        // Too short to form a window: Layer_Done two cycles after Start.
        resetScoreboard();
        Row_Num_After_Padding = FW'(2);
        Channel_In_Num_REG    = CW'(32);
        pulseStart();
        @(negedge clk);
        checkOutput("short_layer_done_early", W'(Layer_Done), W'(0));
        @(negedge clk);
        checkOutput("short_layer_done", W'(Layer_Done), W'(1));
        checkOutput("short_busy", W'(Busy), W'(0));
        repeat (3) @(negedge clk);
        checkOutput("short_no_valid", W'(M_Valid), W'(0));
        checkOutput("short_layer_done_count", W'(layerDones), W'(1));

        // Reset in the middle of a row abandons it.
        monOn = 1'b0;
        Row_Num_After_Padding = FW'(6);
        Channel_In_Num_REG    = CW'(32);
        pulseStart();
        pulseStartRow();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        stallCycles = 0;
        resetScoreboard();
        monOn = 1'b1;
        applyStimulus(7, 48, 1'b1, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
